instr_dcd_burst: RTL and testbench

Parametrised successor of the single-byte SPI instruction decoder. Sits between the SPI slave (byte_sync/data_in/data_out) and the register block (read/write/addr/data).
- Supports multi-byte register words and address widths beyond 6 bits.
- Supports burst transfers with optional address auto-increment.
- Read data is prefetched so that MISO carries valid data on the byte that follows the command.
- A frame_end abort terminates any transaction.

---
 rtl/instr_dcd_burst.sv | 93 +++++++++
 tb/tb_instr_dcd_burst.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst: SPI command decoder with multi-byte words, burst transfers and read prefetch
module instr_dcd_burst #(
  parameter int ADDR_W     = 6,
  parameter int DATA_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_end,
  input  logic                    byte_sync,
  input  logic [7:0]              data_in,
  output logic [7:0]              data_out,
  output logic                    read,
  output logic                    write,
  output logic [ADDR_W-1:0]       addr,
  input  logic [8*DATA_BYTES-1:0] data_read,
  output logic [8*DATA_BYTES-1:0] data_write,
  output logic                    active
);
  typedef enum logic [1:0] {S_CMD, S_ADDR, S_DATA, S_RDWAIT} state_t;
  localparam bit LONG = ADDR_W > 6;
  localparam logic [2:0] NB = 3'(DATA_BYTES);
  state_t state, nxt;
  logic rw, inc, rd_d, bs, last;
  logic [1:0] idx;
  logic [2:0] idx_n;
  logic [5:0] hi;
  logic [31:0] shadow, wbuf, wword;
  assign bs = byte_sync && !frame_end;
  assign idx_n = {1'b0, idx} + 3'd1;
  assign last = idx_n == NB;
  always_comb begin
    wword = wbuf;
    wword[{idx, 3'b000} +: 8] = data_in;
  end
  always_comb begin
    nxt = state;
    if (frame_end) nxt = S_CMD;
    else case (state)
      S_CMD:   if (byte_sync) nxt = LONG ? S_ADDR : data_in[7] ? S_DATA : S_RDWAIT;
      S_ADDR:  if (byte_sync) nxt = rw ? S_DATA : S_RDWAIT;
      S_DATA:  if (byte_sync && !rw && last) nxt = S_RDWAIT;
      default: if (rd_d) nxt = S_DATA;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? S_CMD : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      read       <= 1'b0;
      write      <= 1'b0;
      rd_d       <= 1'b0;
      active     <= 1'b0;
      addr       <= '0;
      data_out   <= '0;
      data_write <= '0;
      idx        <= '0;
      rw         <= 1'b0;
      inc        <= 1'b0;
      hi         <= '0;
      shadow     <= '0;
      wbuf       <= '0;
    end else begin
      read   <= state == S_RDWAIT && !read && !rd_d && !frame_end;
      rd_d   <= read;
      write  <= bs && state == S_DATA && rw && last;
      active <= frame_end ? 1'b0 : (state == S_CMD && byte_sync) | active;
      if (rd_d) begin
        shadow   <= 32'(data_read);
        data_out <= data_read[7:0];
      end
      if (write) addr <= addr + ADDR_W'(inc);
      if (frame_end) idx <= '0;
      if (bs) case (state)
        S_CMD: begin
          rw   <= data_in[7];
          inc  <= data_in[6];
          hi   <= data_in[5:0];
          addr <= LONG ? ADDR_W'({data_in[5:0], 8'(addr)}) : ADDR_W'(data_in[5:0]);
        end
        S_ADDR: addr <= ADDR_W'({hi, data_in});
        S_DATA: begin
          idx <= last ? 2'd0 : idx_n[1:0];
          if (rw) begin
            wbuf <= wword;
            if (last) data_write <= wword[8*DATA_BYTES-1:0];
          end
          else if (last) addr <= addr + ADDR_W'(inc);
          else data_out <= shadow[{idx_n[1:0], 3'b000} +: 8];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb_instr_dcd_burst: three configurations driven by one byte stream, checked against a frame-level model
module tb_instr_dcd_burst;
  logic clk = 1'b0;
  logic rst, frame_end, byte_sync;
  logic [7:0] data_in;
  logic [7:0] dout0, dout1, dout2;
  logic rd0, rd1, rd2, wr0, wr1, wr2, act0, act1, act2;
  logic [5:0] addr0;
  logic [9:0] addr1;
  logic [7:0] addr2;
  logic [7:0] dr0, dw0;
  logic [15:0] dr1, dw1;
  logic [31:0] dr2, dw2;
  logic [7:0] mem0 [64];
  logic [15:0] mem1 [1024];
  logic [31:0] mem2 [256];
  int total = 0, bad = 0;
  logic [7:0] fq[$];
  int pa[3];
  logic [63:0] exp_w[3][$], got_w[3][$];
  int exp_r[3][$], got_r[3][$], exp_do[3][$];
  int bw[3], br[3];
  bit prd[3], pwr[3];

  always #5 clk = ~clk;

  instr_dcd_burst #(.ADDR_W(6), .DATA_BYTES(1)) dut0 (.clk(clk), .rst(rst), .frame_end(frame_end),
    .byte_sync(byte_sync), .data_in(data_in), .data_out(dout0), .read(rd0), .write(wr0), .addr(addr0),
    .data_read(dr0), .data_write(dw0), .active(act0));
  instr_dcd_burst #(.ADDR_W(10), .DATA_BYTES(2)) dut1 (.clk(clk), .rst(rst), .frame_end(frame_end),
    .byte_sync(byte_sync), .data_in(data_in), .data_out(dout1), .read(rd1), .write(wr1), .addr(addr1),
    .data_read(dr1), .data_write(dw1), .active(act1));
  instr_dcd_burst #(.ADDR_W(8), .DATA_BYTES(4)) dut2 (.clk(clk), .rst(rst), .frame_end(frame_end),
    .byte_sync(byte_sync), .data_in(data_in), .data_out(dout2), .read(rd2), .write(wr2), .addr(addr2),
    .data_read(dr2), .data_write(dw2), .active(act2));

  // register block stubs: data valid the cycle after read, junk otherwise
  always @(posedge clk) begin
    dr0 <= rd0 ? mem0[addr0] : 8'($urandom);
    dr1 <= rd1 ? mem1[addr1] : 16'($urandom);
    dr2 <= rd2 ? mem2[addr2] : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int aw(input int c); return c == 0 ? 6 : c == 1 ? 10 : 8; endfunction
  function automatic int db(input int c); return c == 0 ? 1 : c == 1 ? 2 : 4; endfunction
  function automatic logic [31:0] memrd(input int c, input int a);
    return c == 0 ? 32'(mem0[a[5:0]]) : c == 1 ? 32'(mem1[a[9:0]]) : mem2[a[7:0]];
  endfunction
  function automatic logic [31:0] o_addr(input int c);
    return c == 0 ? 32'(addr0) : c == 1 ? 32'(addr1) : 32'(addr2);
  endfunction
  function automatic logic [31:0] o_dw(input int c);
    return c == 0 ? 32'(dw0) : c == 1 ? 32'(dw1) : dw2;
  endfunction
  function automatic logic [7:0] o_dout(input int c); return c == 0 ? dout0 : c == 1 ? dout1 : dout2; endfunction
  function automatic logic o_act(input int c); return c == 0 ? act0 : c == 1 ? act1 : act2; endfunction
  function automatic logic o_rd(input int c); return c == 0 ? rd0 : c == 1 ? rd1 : rd2; endfunction
  function automatic logic o_wr(input int c); return c == 0 ? wr0 : c == 1 ? wr1 : wr2; endfunction

  always @(negedge clk)
    for (int c = 0; c < 3; c++) begin
      if (o_wr(c)) got_w[c].push_back({o_addr(c), o_dw(c)});
      if (o_rd(c)) got_r[c].push_back(int'(o_addr(c)));
      if (o_rd(c) || o_wr(c)) chk("strobe_excl", {prd[c] && o_rd(c), pwr[c] && o_wr(c), o_rd(c) && o_wr(c)}, 0);
      prd[c] = o_rd(c);
      pwr[c] = o_wr(c);
    end

  // expected writes, reads, MISO bytes and final address for a frame of which n bytes are accepted
  task automatic predict(input int c, input int n);
    int hdr = aw(c) > 6 ? 2 : 1;
    int mask = (1 << aw(c)) - 1;
    int a = pa[c];
    logic [31:0] word = 0;
    logic rw = fq[0][7];
    logic inc = fq[0][6];
    exp_w[c].delete();
    exp_r[c].delete();
    exp_do[c].delete();
    for (int i = 0; i < fq.size(); i++) exp_do[c].push_back(-1);
    if (n >= 1) a = aw(c) > 6 ? ((a & 255) | (int'(fq[0][5:0]) << 8)) & mask : int'(fq[0][5:0]) & mask;
    if (n >= hdr && hdr == 2) a = ((int'(fq[0][5:0]) << 8) | int'(fq[1])) & mask;
    if (n >= hdr && !rw) exp_r[c].push_back(a);
    for (int i = hdr; i < fq.size(); i++) begin
      int lane = (i - hdr) % db(c);
      if (!rw) exp_do[c][i] = int'((memrd(c, a) >> (8 * lane)) & 32'hFF);
      if (i < n) begin
        if (rw) word[8*lane +: 8] = fq[i];
        if (lane == db(c) - 1) begin
          if (rw) exp_w[c].push_back({32'(a), word});
          a = inc ? (a + 1) & mask : a;
          if (!rw) exp_r[c].push_back(a);
        end
      end
    end
    pa[c] = a;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe);
    @(negedge clk);
    byte_sync = 1'b1;
    data_in = b;
    frame_end = fe;
    @(negedge clk);
    byte_sync = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic run_frame(input bit coinc);
    int n = fq.size() - (coinc ? 1 : 0);
    for (int c = 0; c < 3; c++) begin
      predict(c, n);
      bw[c] = got_w[c].size();
      br[c] = got_r[c].size();
    end
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++)
        if (exp_do[c][i] >= 0) chk("miso", o_dout(c), exp_do[c][i]);
      send_byte(fq[i], coinc && i == fq.size() - 1);
      for (int c = 0; c < 3; c++) chk("active", o_act(c), !(coinc && i == fq.size() - 1));
      repeat ($urandom_range(3, 6)) @(negedge clk);
    end
    if (!coinc) begin
      frame_end = 1'b1;
      @(negedge clk);
      frame_end = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("active_end", o_act(c), 0);
      chk("addr_end", o_addr(c), pa[c]);
      chk("n_writes", got_w[c].size() - bw[c], exp_w[c].size());
      for (int k = 0; k < exp_w[c].size() && bw[c] + k < got_w[c].size(); k++)
        chk("write", got_w[c][bw[c]+k], exp_w[c][k]);
      chk("n_reads", got_r[c].size() - br[c], exp_r[c].size());
      for (int k = 0; k < exp_r[c].size() && br[c] + k < got_r[c].size(); k++)
        chk("read_addr", got_r[c][br[c]+k], exp_r[c][k]);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk({tag, "_addr"}, o_addr(c), 0);
      chk({tag, "_dout"}, o_dout(c), 0);
      chk({tag, "_dw"}, o_dw(c), 0);
      chk({tag, "_flags"}, {o_act(c), o_rd(c), o_wr(c)}, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem0[i] = 8'($urandom);
    for (int i = 0; i < 1024; i++) mem1[i] = 16'($urandom);
    for (int i = 0; i < 256; i++) mem2[i] = $urandom;
    mem0[3] = 8'hC3;
    mem1[10'h210] = 16'hBEEF;
    rst = 1'b1;
    frame_end = 1'b0;
    byte_sync = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b0;
    fq = '{8'h85, 8'h5A};               run_frame(1'b0);
    fq = '{8'h03, 8'h00, 8'h00};        run_frame(1'b0);
    fq = '{8'h43, 8'h00, 8'h00};        run_frame(1'b0);
    fq = '{8'hFE, 8'h11, 8'h22, 8'h33}; run_frame(1'b0);
    fq = '{8'h82, 8'h10, 8'h34, 8'h12}; run_frame(1'b0);
    fq = '{8'h02, 8'h10, 8'h00, 8'h00}; run_frame(1'b0);
    fq = '{8'hC0, 8'h01, 8'h02, 8'h03}; run_frame(1'b0);
    fq = '{8'h81, 8'h77, 8'h66};        run_frame(1'b1);
    fq = '{8'h85};                      run_frame(1'b1);
    // reset while a read prefetch is about to be issued
    send_byte(8'h47, 1'b0);
    repeat (4) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      bw[c] = got_w[c].size();
      br[c] = got_r[c].size();
    end
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid_reset");
    repeat (5) @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      chk("mid_reset_strobes", (got_w[c].size() - bw[c]) + (got_r[c].size() - br[c]), 0);
      pa[c] = 0;
    end
    for (int f = 0; f < 60; f++) begin
      int len = $urandom_range(1, 7);
      fq.delete();
      for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
      run_frame($urandom_range(0, 3) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
